fsm_seq: RTL and testbench

Programmable micro-sequencer that drives the register-file/ALU datapath control lines from a loadable program memory. It replaces the fixed-step controller: per-cycle control words (immediate, register write enable, mux selects, opcode, bus enable) are fetched from an internal array rather than hard-coded. It adds start/done handshake, jump and halt flow control, a watchdog, and abort. It sits between the board-level control (push button or host loader) and the datapath mux/ALU/register enables.

---
 rtl/fsm_seq.sv | 199 +++++++++++++++++++
 tb/tb_fsm_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_seq.sv
// fsm_seq: programmable micro-sequencer for the register-file/ALU datapath.
// Control words are fetched from a loadable program memory, one word issued per
// cycle while running. NEXT/JUMP/HALT flow control, a watchdog on the number of
// issued words, abort, and a start/done handshake. All outputs are registered.
module fsm_seq #(
    parameter int DATA_W  = 16,
    parameter int NREG    = 16,
    parameter int RIDX_W  = 4,
    parameter int SEL_W   = 5,
    parameter int OP_W    = 8,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int WDOG    = 256,
    parameter int INSTR_W = 2 + ADDR_W + 1 + RIDX_W + OP_W + 2*SEL_W + 1 + DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_wdata,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [DATA_W-1:0]  immediate,
    output logic [NREG-1:0]    enable,
    output logic [SEL_W-1:0]   control1,
    output logic [SEL_W-1:0]   control2,
    output logic               imm_control,
    output logic [OP_W-1:0]    opcode,
    output logic               buff_en
);

    // Field positions inside an instruction word (LSB first).
    localparam int IMM_LSB  = 0;
    localparam int IMS_BIT  = DATA_W;
    localparam int SRC2_LSB = IMS_BIT + 1;
    localparam int SRC1_LSB = SRC2_LSB + SEL_W;
    localparam int OP_LSB   = SRC1_LSB + SEL_W;
    localparam int DST_LSB  = OP_LSB + OP_W;
    localparam int WR_BIT   = DST_LSB + RIDX_W;
    localparam int TGT_LSB  = WR_BIT + 1;
    localparam int CTL_LSB  = TGT_LSB + ADDR_W;

    // Step counter must be able to hold WDOG itself.
    localparam int CNT_W = $clog2(WDOG + 1);

    localparam logic [1:0] CTL_JUMP = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t              state, state_nx;
    logic [INSTR_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0]   pc, pc_nx, rd_addr;
    logic [CNT_W-1:0]    step, step_nx;
    logic                err_nx, done_nx;
    logic                fin, fin_nx;   // last issued word was HALT or reserved
    logic                rsv, rsv_nx;   // last issued word was the reserved ctl
    logic                issue;
    logic [INSTR_W-1:0]  word;
    logic [1:0]          ctl;
    logic                wr;
    logic [RIDX_W-1:0]   dst;

    logic [DATA_W-1:0]   immediate_nx;
    logic [NREG-1:0]     enable_nx;
    logic [SEL_W-1:0]    control1_nx, control2_nx;
    logic                imm_control_nx, buff_en_nx;
    logic [OP_W-1:0]     opcode_nx;

    // Program memory: loaded only while idle and not starting; never reset.
    always_ff @(posedge clk) begin
        if (prog_we && (state == S_IDLE) && !start)
            mem[prog_addr] <= prog_wdata;
    end

    // Next-state, next-pc and next-output decode.
    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        step_nx        = step;
        err_nx         = err;
        done_nx        = 1'b0;
        fin_nx         = fin;
        rsv_nx         = rsv;
        issue          = 1'b0;
        rd_addr        = pc;
        immediate_nx   = '0;
        enable_nx      = '0;
        control1_nx    = '0;
        control2_nx    = '0;
        imm_control_nx = 1'b0;
        opcode_nx      = '0;
        buff_en_nx     = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    issue    = 1'b1;
                    rd_addr  = '0;
                    step_nx  = CNT_W'(1);
                    err_nx   = 1'b0;
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (fin) begin
                    state_nx = S_DONE;
                    done_nx  = 1'b1;
                    if (rsv)
                        err_nx = 1'b1;
                end else if (step == CNT_W'(WDOG)) begin
                    state_nx = S_DONE;
                    done_nx  = 1'b1;
                    err_nx   = 1'b1;
                end else begin
                    issue   = 1'b1;
                    step_nx = step + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        word = mem[rd_addr];
        ctl  = word[CTL_LSB +: 2];
        wr   = word[WR_BIT];
        dst  = word[DST_LSB +: RIDX_W];

        if (issue) begin
            fin_nx = ctl[1];
            rsv_nx = &ctl;
            if (ctl == CTL_JUMP)
                pc_nx = word[TGT_LSB +: ADDR_W];
            else if (rd_addr == ADDR_W'(DEPTH - 1))
                pc_nx = '0;
            else
                pc_nx = rd_addr + ADDR_W'(1);
            immediate_nx   = word[IMM_LSB +: DATA_W];
            imm_control_nx = word[IMS_BIT];
            control2_nx    = word[SRC2_LSB +: SEL_W];
            control1_nx    = word[SRC1_LSB +: SEL_W];
            opcode_nx      = word[OP_LSB +: OP_W];
            buff_en_nx     = wr;
            enable_nx      = wr ? (NREG'(1) << dst) : '0;
        end
    end

    // State, sequencing and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            step        <= '0;
            err         <= 1'b0;
            done        <= 1'b0;
            fin         <= 1'b0;
            rsv         <= 1'b0;
            immediate   <= '0;
            enable      <= '0;
            control1    <= '0;
            control2    <= '0;
            imm_control <= 1'b0;
            opcode      <= '0;
            buff_en     <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            step        <= step_nx;
            err         <= err_nx;
            done        <= done_nx;
            fin         <= fin_nx;
            rsv         <= rsv_nx;
            immediate   <= immediate_nx;
            enable      <= enable_nx;
            control1    <= control1_nx;
            control2    <= control2_nx;
            imm_control <= imm_control_nx;
            opcode      <= opcode_nx;
            buff_en     <= buff_en_nx;
        end
    end

    assign busy   = (state == S_RUN);
    assign pc_out = pc;

endmodule

// File: tb/tb_fsm_seq.sv
// Testbench for fsm_seq: table-driven countdown program, hand-written corner
// sequences (async reset mid-run, abort, program writes, watchdog, wrap,
// reserved ctl) and random programs checked against a run-level model.
module tb_fsm_seq;

    localparam int DATA_W  = 16;
    localparam int NREG    = 16;
    localparam int RIDX_W  = 4;
    localparam int SEL_W   = 5;
    localparam int OP_W    = 8;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int WDOG    = 8;
    localparam int INSTR_W = 46;

    typedef struct packed {
        logic [1:0]  ctl;
        logic [3:0]  tgt;
        logic        wr;
        logic [3:0]  dst;
        logic [7:0]  op;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic        ims;
        logic [15:0] imm;
    } fld_t;

    typedef struct {
        fld_t        f;
        logic [15:0] en;
        logic [4:0]  c1;
        logic [7:0]  op;
        logic [15:0] imm;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               prog_we = 1'b0;
    logic [ADDR_W-1:0]  prog_addr = '0;
    logic [INSTR_W-1:0] prog_wdata = '0;
    logic               busy, done, err;
    logic [ADDR_W-1:0]  pc_out;
    logic [DATA_W-1:0]  immediate;
    logic [NREG-1:0]    enable;
    logic [SEL_W-1:0]   control1, control2;
    logic               imm_control;
    logic [OP_W-1:0]    opcode;
    logic               buff_en;

    fsm_seq #(
        .DATA_W(DATA_W), .NREG(NREG), .RIDX_W(RIDX_W), .SEL_W(SEL_W), .OP_W(OP_W),
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WDOG(WDOG), .INSTR_W(INSTR_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .busy(busy), .done(done), .err(err), .pc_out(pc_out),
        .immediate(immediate), .enable(enable), .control1(control1),
        .control2(control2), .imm_control(imm_control), .opcode(opcode),
        .buff_en(buff_en)
    );

    always #5 clk = ~clk;

    fld_t prog [DEPTH];
    int   nvec = 0;
    int   nerr = 0;
    int   exp_idx[$];
    int   exp_pc[$];
    bit   exp_err;

    logic [51:0] act_dp;
    assign act_dp = {immediate, enable, control1, control2, imm_control, opcode, buff_en};

    function automatic fld_t mkf(input logic [1:0] ctl, input logic [3:0] tgt, input logic wr,
                                 input logic [3:0] dst, input logic [7:0] op, input logic [4:0] s1,
                                 input logic [4:0] s2, input logic ims, input logic [15:0] imm);
        fld_t f;
        f.ctl = ctl; f.tgt = tgt; f.wr = wr; f.dst = dst; f.op = op;
        f.src1 = s1; f.src2 = s2; f.ims = ims; f.imm = imm;
        return f;
    endfunction

    // Datapath lines the word is expected to drive while issued.
    function automatic logic [51:0] exp_dp(input fld_t f);
        logic [15:0] en;
        en = f.wr ? (16'(1) << f.dst) : 16'h0;
        return {f.imm, en, f.src1, f.src2, f.ims, f.op, f.wr};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic chk_quiet(input string name, input logic exp_done, input logic exp_e);
        chk({name, "_dp"}, 64'(act_dp), 64'h0);
        chk({name, "_busy"}, 64'(busy), 64'h0);
        chk({name, "_done"}, 64'(done), 64'(exp_done));
        chk({name, "_err"}, 64'(err), 64'(exp_e));
    endtask

    task automatic write_prog(input int addr, input fld_t f, input bit accepted);
        @(negedge clk);
        prog_we    = 1'b1;
        prog_addr  = ADDR_W'(addr);
        prog_wdata = f;
        @(negedge clk);
        prog_we    = 1'b0;
        if (accepted) prog[addr] = f;
    endtask

    // Walk the program the way a run is defined: issue, then stop on HALT /
    // reserved, or when WDOG words have been issued, else follow NEXT/JUMP.
    task automatic model_run();
        int idx, n, nxt;
        exp_idx.delete();
        exp_pc.delete();
        idx = 0;
        n = 0;
        while (1) begin
            exp_idx.push_back(idx);
            n++;
            if (prog[idx].ctl >= 2) begin
                exp_pc.push_back(-1);
                exp_err = (prog[idx].ctl == 2'b11);
                break;
            end
            nxt = (prog[idx].ctl == 2'b01) ? int'(prog[idx].tgt) : (idx + 1) % DEPTH;
            exp_pc.push_back(nxt);
            if (n == WDOG) begin
                exp_err = 1'b1;
                break;
            end
            idx = nxt;
        end
    endtask

    task automatic do_run(input string tag);
        model_run();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < exp_idx.size(); i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            chk({tag, "_dp"}, 64'(act_dp), 64'(exp_dp(prog[exp_idx[i]])));
            chk({tag, "_busy"}, 64'(busy), 64'h1);
            chk({tag, "_err_run"}, 64'(err), 64'h0);
            if (exp_pc[i] >= 0) chk({tag, "_pc"}, 64'(pc_out), 64'(exp_pc[i]));
        end
        @(posedge clk); #1;
        chk_quiet({tag, "_end"}, 1'b1, exp_err);
        @(posedge clk); #1;
        chk_quiet({tag, "_idle"}, 1'b0, exp_err);
    endtask

    vec_t tbl [5];

    initial begin
        fld_t f;
        logic [63:0] r;
        int k;

        tbl[0].f = mkf(2'b00, 4'd0, 1'b1, 4'd1, 8'h05, 5'd1, 5'd0, 1'b1, 16'd10);
        tbl[0].en = 16'h0002; tbl[0].c1 = 5'd1; tbl[0].op = 8'h05; tbl[0].imm = 16'd10;
        tbl[1].f = mkf(2'b00, 4'd0, 1'b1, 4'd2, 8'h09, 5'd2, 5'd0, 1'b1, 16'd1);
        tbl[1].en = 16'h0004; tbl[1].c1 = 5'd2; tbl[1].op = 8'h09; tbl[1].imm = 16'd1;
        tbl[2].f = mkf(2'b00, 4'd0, 1'b1, 4'd3, 8'h09, 5'd3, 5'd0, 1'b1, 16'd1);
        tbl[2].en = 16'h0008; tbl[2].c1 = 5'd3; tbl[2].op = 8'h09; tbl[2].imm = 16'd1;
        tbl[3].f = mkf(2'b00, 4'd0, 1'b1, 4'd4, 8'h09, 5'd4, 5'd0, 1'b1, 16'd1);
        tbl[3].en = 16'h0010; tbl[3].c1 = 5'd4; tbl[3].op = 8'h09; tbl[3].imm = 16'd1;
        tbl[4].f = mkf(2'b10, 4'd0, 1'b1, 4'd5, 8'h09, 5'd5, 5'd0, 1'b1, 16'd1);
        tbl[4].en = 16'h0020; tbl[4].c1 = 5'd5; tbl[4].op = 8'h09; tbl[4].imm = 16'd1;

        for (int i = 0; i < DEPTH; i++) prog[i] = '0;

        // Reset state.
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset", 1'b0, 1'b0);
        chk("reset_pc", 64'(pc_out), 64'h0);
        @(negedge clk);
        reset = 1'b1;

        // Countdown program from the vector table.
        for (int i = 0; i < 5; i++) write_prog(i, tbl[i].f, 1'b1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            chk("cd_enable", 64'(enable), 64'(tbl[i].en));
            chk("cd_control1", 64'(control1), 64'(tbl[i].c1));
            chk("cd_opcode", 64'(opcode), 64'(tbl[i].op));
            chk("cd_immediate", 64'(immediate), 64'(tbl[i].imm));
            chk("cd_busy", 64'(busy), 64'h1);
        end
        @(posedge clk); #1;
        chk_quiet("cd_done", 1'b1, 1'b0);
        @(posedge clk); #1;
        chk_quiet("cd_after", 1'b0, 1'b0);

        // Asynchronous reset in the middle of the third issue cycle.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk_quiet("rst_mid", 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        do_run("rst_rerun");

        // Abort while the second word is on the datapath.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("abort_pre", 64'(enable), 64'h0004);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk_quiet("abort", 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", 64'(done), 64'h0);
        end

        // Write to address 2 while running is ignored, now and on the next run.
        f = tbl[2].f;
        f.imm = 16'hBEEF;
        fork
            do_run("we_run");
            begin
                @(posedge clk);
                write_prog(2, f, 1'b0);
            end
        join
        do_run("we_run_next");
        write_prog(2, f, 1'b1);
        do_run("we_idle");

        // Write in the same cycle as start is ignored.
        @(negedge clk);
        start      = 1'b1;
        prog_we    = 1'b1;
        prog_addr  = '0;
        prog_wdata = mkf(2'b10, 4'd0, 1'b0, 4'd0, 8'hAA, 5'd7, 5'd7, 1'b0, 16'h1234);
        @(posedge clk); #1;
        start   = 1'b0;
        prog_we = 1'b0;
        chk("clash_dp", 64'(act_dp), 64'(exp_dp(prog[0])));
        chk("clash_busy", 64'(busy), 64'h1);
        repeat (8) @(posedge clk);
        #1;
        chk_quiet("clash_settle", 1'b0, 1'b0);
        do_run("clash_rerun");

        // JUMP loop with no HALT: watchdog ends it, err clears on next start.
        write_prog(0, mkf(2'b00, 4'd0, 1'b1, 4'd6, 8'h11, 5'd1, 5'd2, 1'b0, 16'h0101), 1'b1);
        write_prog(1, mkf(2'b01, 4'd0, 1'b1, 4'd7, 8'h22, 5'd3, 5'd4, 1'b1, 16'h0202), 1'b1);
        do_run("wdog");
        do_run("wdog_again");

        // NEXT at the last address wraps to address 0.
        write_prog(0, mkf(2'b01, 4'd15, 1'b0, 4'd0, 8'h33, 5'd5, 5'd6, 1'b0, 16'h3333), 1'b1);
        write_prog(15, mkf(2'b00, 4'd9, 1'b1, 4'd15, 8'h44, 5'd8, 5'd9, 1'b1, 16'h4444), 1'b1);
        do_run("wrap");

        // Reserved ctl ends the run after issuing it, with err.
        write_prog(0, mkf(2'b00, 4'd0, 1'b1, 4'd3, 8'h55, 5'd1, 5'd1, 1'b0, 16'h5555), 1'b1);
        write_prog(1, mkf(2'b11, 4'd0, 1'b1, 4'd9, 8'h66, 5'd2, 5'd2, 1'b1, 16'h6666), 1'b1);
        do_run("reserved");

        // Random programs.
        for (int p = 0; p < 6; p++) begin
            for (int a = 0; a < DEPTH; a++) begin
                r = {$urandom, $urandom};
                f = r[45:0];
                k = $urandom_range(0, 9);
                f.ctl = (k < 6) ? 2'b00 : (k < 8) ? 2'b01 : (k < 9) ? 2'b10 : 2'b11;
                write_prog(a, f, 1'b1);
            end
            do_run("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
